// File: rtl/iram_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives the IRAM read and emits one load strobe per fetch.
// Optional macro IFU_BOUND_CHECK_EN rejects fetch targets above PROG_LAST and raises a sticky fetch_fault.
module iram_fetch_unit #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int PROG_LAST    = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_address,
    output logic [ADDR_W-1:0] iram_addr,
    output logic              iram_rd_en,
    output logic              load_instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        LAT_M1    = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);
    // DATA_W only documents the IRAM word the instruction register captures.
    localparam int unused_params = DATA_W + PROG_LAST;

    state_t            state_r;
    logic [2:0]        cnt_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] addr_r;
    logic              rd_en_r;
    logic              load_r;
    logic              busy_r;
    logic              done_r;
    logic              pend_valid_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [ADDR_W-1:0] target_s;

    // Fetch target: a jump presented with the request wins over the PC.
    always_comb begin
        target_s = pc_r;
        if (jump_valid) begin
            target_s = jump_address;
        end else begin
            target_s = pc_r;
        end
    end

`ifdef IFU_BOUND_CHECK_EN
    localparam logic [ADDR_W-1:0] PROG_LAST_A = ADDR_W'(PROG_LAST);
    logic fault_r;
    logic out_of_range_s;

    // Range check of the fetch target against the last legal instruction address.
    always_comb begin
        out_of_range_s = 1'b0;
        if (target_s > PROG_LAST_A) begin
            out_of_range_s = 1'b1;
        end else begin
            out_of_range_s = 1'b0;
        end
    end

    // Sticky fault flag, set by a rejected fetch in IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_r <= 1'b0;
        end else if (state_r == S_IDLE && fetch_req && out_of_range_s) begin
            fault_r <= 1'b1;
        end
    end

    assign fetch_fault = fault_r;
`else
    assign fetch_fault = 1'b0;
`endif

    // Fetch FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            cnt_r        <= 3'd0;
            pc_r         <= ADDR_ZERO;
            addr_r       <= ADDR_ZERO;
            rd_en_r      <= 1'b0;
            load_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_addr_r  <= ADDR_ZERO;
        end else begin
            rd_en_r <= 1'b0;
            load_r  <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (fetch_req) begin
`ifdef IFU_BOUND_CHECK_EN
                        if (out_of_range_s) begin
                            done_r <= 1'b1;
                        end else begin
                            pc_r    <= target_s;
                            addr_r  <= target_s;
                            rd_en_r <= 1'b1;
                            busy_r  <= 1'b1;
                            state_r <= S_ISSUE;
                        end
`else
                        pc_r    <= target_s;
                        addr_r  <= target_s;
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= S_ISSUE;
`endif
                    end else if (jump_valid) begin
                        pc_r <= jump_address;
                    end
                end
                S_ISSUE: begin
                    if (jump_valid) begin
                        pend_valid_r <= 1'b1;
                        pend_addr_r  <= jump_address;
                    end
                    if (READ_LATENCY == 0) begin
                        load_r  <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= S_LOAD;
                    end else begin
                        cnt_r   <= LAT_M1;
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (jump_valid) begin
                        pend_valid_r <= 1'b1;
                        pend_addr_r  <= jump_address;
                    end
                    if (cnt_r == 3'd0) begin
                        load_r  <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= S_LOAD;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                S_LOAD: begin
                    // A jump arriving in this very cycle is newer than any pending one.
                    if (jump_valid) begin
                        pc_r <= jump_address;
                    end else if (pend_valid_r) begin
                        pc_r <= pend_addr_r;
                    end else begin
                        pc_r <= pc_r + ADDR_ONE;
                    end
                    pend_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign iram_addr        = addr_r;
    assign iram_rd_en       = rd_en_r;
    assign load_instruction = load_r;
    assign pc               = pc_r;
    assign busy             = busy_r;
    assign fetch_done       = done_r;

endmodule

// File: tb/tb_iram_fetch_unit.sv
// Self-checking bench for iram_fetch_unit: directed scenarios plus random traffic against a
// transaction-level model that counts cycles since fetch acceptance.
module tb_iram_fetch_unit;

    localparam int AW  = 8;
    localparam int LAT = 1;
`ifdef IFU_BOUND_CHECK_EN
    localparam int PL    = 15;
    localparam bit BOUND = 1'b1;
`else
    localparam int PL    = 255;
    localparam bit BOUND = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic          jump_valid = 1'b0;
    logic [AW-1:0] jump_address = '0;
    logic [AW-1:0] iram_addr;
    logic          iram_rd_en;
    logic          load_instruction;
    logic [AW-1:0] pc;
    logic          busy;
    logic          fetch_done;
    logic          fetch_fault;

    int total = 0;
    int bad = 0;

    // Model: cycles elapsed since the fetch was accepted (0 = idle).
    int m_pc, m_addr, m_ph, m_pend, m_paddr;
    bit m_fault, m_fpulse;

    always #5 clock = ~clock;

    iram_fetch_unit #(
        .ADDR_W(AW), .DATA_W(16), .READ_LATENCY(LAT), .PROG_LAST(PL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .fetch_req(fetch_req),
        .jump_valid(jump_valid), .jump_address(jump_address),
        .iram_addr(iram_addr), .iram_rd_en(iram_rd_en),
        .load_instruction(load_instruction), .pc(pc), .busy(busy),
        .fetch_done(fetch_done), .fetch_fault(fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_addr = 0; m_ph = 0; m_pend = 0; m_paddr = 0;
        m_fault = 1'b0; m_fpulse = 1'b0;
    endtask

    task automatic model_step();
        int tgt;
        m_fpulse = 1'b0;
        if (m_ph == 0) begin
            if (fetch_req) begin
                tgt = jump_valid ? int'(jump_address) : m_pc;
                if (BOUND && tgt > PL) begin
                    m_fault  = 1'b1;
                    m_fpulse = 1'b1;
                end else begin
                    m_pc = tgt; m_addr = tgt; m_ph = 1;
                end
            end else if (jump_valid) begin
                m_pc = int'(jump_address);
            end
        end else if (m_ph == LAT + 2) begin
            if (jump_valid)  m_pc = int'(jump_address);
            else if (m_pend != 0) m_pc = m_paddr;
            else             m_pc = (m_pc + 1) % (1 << AW);
            m_pend = 0;
            m_ph = 0;
        end else begin
            if (jump_valid) begin
                m_pend = 1; m_paddr = int'(jump_address);
            end
            m_ph++;
        end
    endtask

    task automatic check_outputs();
        bit exp_load;
        exp_load = (m_ph == LAT + 2);
        chk("pc", 32'(pc), m_pc);
        chk("iram_addr", 32'(iram_addr), m_addr);
        chk("rd_en", 32'(iram_rd_en), 32'(m_ph == 1));
        chk("load", 32'(load_instruction), 32'(exp_load));
        chk("done", 32'(fetch_done), 32'(exp_load | m_fpulse));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("fault", 32'(fetch_fault), 32'(m_fault));
        chk("excl", 32'(iram_rd_en & load_instruction), 32'd0);
    endtask

    // Drive at the falling edge, step the model at the rising edge, check at the next falling edge.
    task automatic cycle(input bit rq, input bit jv, input logic [AW-1:0] ja);
        fetch_req = rq; jump_valid = jv; jump_address = ja;
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs();
        reset_n = 1'b1;

        // First fetch from pc 0.
        cycle(1'b1, 1'b0, 8'h00);
        idle(LAT + 3);

        // Walk across the address wrap.
        cycle(1'b0, 1'b1, 8'hFE);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 8'h00);
            idle(LAT + 2);
        end

        // Fetch and jump together.
        cycle(1'b1, 1'b1, 8'h40);
        idle(LAT + 3);

        // Jump while waiting on IRAM, then a follow-up fetch.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h20);
        idle(LAT + 1);
        cycle(1'b1, 1'b0, 8'h00);
        idle(LAT + 3);

        // Reset in the middle of a fetch.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        check_outputs();
        reset_n = 1'b1;
        idle(2);
        cycle(1'b1, 1'b0, 8'h00);
        idle(LAT + 3);

        // Jump to 0x10 then fetch: beyond PROG_LAST when bound checking is on.
        cycle(1'b0, 1'b1, 8'h10);
        cycle(1'b1, 1'b0, 8'h00);
        idle(LAT + 3);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                  8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
